// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
//
// Single-port word/byte RAM behind a three-state request/response handshake.
// A request is sampled in IDLE. The memory operation is performed in ACCESS.
// The result is presented for one cycle in RESP. The responder therefore
// accepts at most one request every three cycles.
//
// Parameters
//   ADDR_WIDTH  word-address width (1..15); the array holds 2**ADDR_WIDTH
//               16-bit words
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         request strobe, only looked at while IDLE
//   addr        byte address: word index addr[ADDR_WIDTH:1], byte lane addr[0]
//   rw_n        1 = read, 0 = write
//   ebit        1 = byte access, 0 = word access
//   write_data  write data (byte writes use write_data[7:0])
//   read_data   registered read result, meaningful while ack=1, held after
//   ack         one-cycle completion pulse (the RESP cycle)
//   err         address above the array, meaningful while ack=1, held after
//   busy        high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module data_ram_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        rw_n,
    input  logic        ebit,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;

    // Captured request. These registers hold data only: they are qualified by
    // the FSM state, which carries the reset, so they need no reset.
    logic [15:0]           req_addr;
    logic [15:0]           req_wdata;
    logic                  req_rw_n;
    logic                  req_ebit;

    logic [15:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [15:0]           mem_word;
    logic                  out_of_range;
    logic                  wr_en;
    logic                  capture;

    // Selects the read result: the whole word, or the addressed byte
    // zero-extended into the low lane.
    function automatic logic [15:0] read_select(
        input logic [15:0] word,
        input logic        byte_acc,
        input logic        lane
    );
        logic [15:0] res;
        res = word;
        if (byte_acc) begin
            res = lane ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
        end
        return res;
    endfunction

    // Builds the word to store. A byte write is a read-modify-write of the
    // current word so that the other lane is preserved.
    function automatic logic [15:0] write_merge(
        input logic [15:0] old_word,
        input logic [15:0] wdata,
        input logic        byte_acc,
        input logic        lane
    );
        logic [15:0] res;
        res = wdata;
        if (byte_acc) begin
            res = lane ? {wdata[7:0], old_word[7:0]} : {old_word[15:8], wdata[7:0]};
        end
        return res;
    endfunction

    assign word_idx     = req_addr[ADDR_WIDTH:1];
    assign mem_word     = mem[word_idx];
    // Any address bit above the word index and byte lane means the access
    // falls outside the array. The shift form stays legal for ADDR_WIDTH=15.
    assign out_of_range = (req_addr >> (ADDR_WIDTH + 1)) != 16'h0000;
    assign wr_en        = (state == ST_ACCESS) && !req_rw_n && !out_of_range;
    assign capture      = (state == ST_IDLE) && req;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:   state_nxt = req ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- IDLE -> ACCESS: request capture ----
    always_ff @(posedge clk) begin
        if (capture) begin
            req_addr  <= addr;
            req_wdata <= write_data;
            req_rw_n  <= rw_n;
            req_ebit  <= ebit;
        end
    end

    // ---- ACCESS -> RESP: memory commit and response registers ----
    // The array is never reset. A reset that lands while in ACCESS returns the
    // FSM to IDLE before the edge, so wr_en is low and the write is dropped.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_idx] <= write_merge(mem_word, req_wdata, req_ebit, req_addr[0]);
        end
    end

    // ack is high for exactly the RESP cycle. read_data and err only change
    // when entering RESP, so they hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= 1'b0;
            err       <= 1'b0;
            read_data <= 16'h0000;
        end else begin
            ack <= (state == ST_ACCESS);
            if (state == ST_ACCESS) begin
                err <= out_of_range;
                if (out_of_range || !req_rw_n) begin
                    read_data <= 16'h0000;
                end else begin
                    read_data <= read_select(mem_word, req_ebit, req_addr[0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [15:0] addr;
    logic        rw_n;
    logic        ebit;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        ack;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    data_ram_responder #(.ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .addr       (addr),
        .rw_n       (rw_n),
        .ebit       (ebit),
        .write_data (write_data),
        .read_data  (read_data),
        .ack        (ack),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction. While the request is in flight the inputs are
    // inverted and req is kept high, which a correct design must ignore.
    task automatic xfer(input string tag, input logic [15:0] a, input logic rw,
                        input logic eb, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req = 1'b1; addr = a; rw_n = rw; ebit = eb; write_data = wd;
        @(posedge clk); #1;
        addr = ~a; rw_n = ~rw; ebit = ~eb; write_data = ~wd;
        chk({tag, ".access_ack"},  {15'h0, ack},  16'h0);
        chk({tag, ".access_busy"}, {15'h0, busy}, 16'h1);
        @(posedge clk); #1;
        chk({tag, ".resp_ack"}, {15'h0, ack}, 16'h1);
        chk({tag, ".resp_rd"},  read_data,    exp_rd);
        chk({tag, ".resp_err"}, {15'h0, err}, {15'h0, exp_err});
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, ".idle_ack"},  {15'h0, ack},  16'h0);
        chk({tag, ".idle_busy"}, {15'h0, busy}, 16'h0);
        chk({tag, ".hold_rd"},   read_data,     exp_rd);
    endtask

    logic exp_busy6 [6];
    logic exp_ack6  [6];
    int   ack_count;

    initial begin
        rst_n = 1'b0; req = 1'b0; addr = 16'h0; rw_n = 1'b1; ebit = 1'b0; write_data = 16'h0;
        exp_busy6 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_ack6  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset values
        #12;
        chk("rst.ack",  {15'h0, ack},  16'h0);
        chk("rst.busy", {15'h0, busy}, 16'h0);
        chk("rst.err",  {15'h0, err},  16'h0);
        chk("rst.rd",   read_data,     16'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Word write then word read
        xfer("w10",   16'h0010, 1'b0, 1'b0, 16'hA55A, 16'h0000, 1'b0);
        xfer("r10",   16'h0010, 1'b1, 1'b0, 16'h0000, 16'hA55A, 1'b0);

        // Byte write to high lane, then word/byte reads
        xfer("bw11",  16'h0011, 1'b0, 1'b1, 16'h00C3, 16'h0000, 1'b0);
        xfer("r10b",  16'h0010, 1'b1, 1'b0, 16'h0000, 16'hC35A, 1'b0);
        xfer("r11w",  16'h0011, 1'b1, 1'b0, 16'h0000, 16'hC35A, 1'b0);
        xfer("br10",  16'h0010, 1'b1, 1'b1, 16'h0000, 16'h005A, 1'b0);
        xfer("br11",  16'h0011, 1'b1, 1'b1, 16'h0000, 16'h00C3, 1'b0);

        // Byte write to low lane keeps the high lane
        xfer("bw10",  16'h0010, 1'b0, 1'b1, 16'hEE77, 16'h0000, 1'b0);
        xfer("r10c",  16'h0010, 1'b1, 1'b0, 16'h0000, 16'hC377, 1'b0);

        // Out of range: 0x0800 aliases word 0 if the write were not suppressed
        xfer("w00",   16'h0000, 1'b0, 1'b0, 16'h1111, 16'h0000, 1'b0);
        xfer("w800",  16'h0800, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        xfer("r00",   16'h0000, 1'b1, 1'b0, 16'h0000, 16'h1111, 1'b0);
        xfer("r800",  16'h0800, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
        xfer("rf000", 16'hF000, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);

        // req held high for six cycles from IDLE
        @(negedge clk);
        req = 1'b1; addr = 16'h0010; rw_n = 1'b1; ebit = 1'b0;
        ack_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("hold6.busy%0d", i + 1), {15'h0, busy}, {15'h0, exp_busy6[i]});
            chk($sformatf("hold6.ack%0d", i + 1),  {15'h0, ack},  {15'h0, exp_ack6[i]});
            if (ack === 1'b1) ack_count++;
        end
        req = 1'b0;
        chk("hold6.count", ack_count[15:0], 16'd2);
        chk("hold6.rd",    read_data,       16'hC377);
        @(negedge clk); @(negedge clk);

        // Reset during ACCESS aborts the write
        xfer("w20",   16'h0020, 1'b0, 1'b0, 16'h0BAD, 16'h0000, 1'b0);
        @(negedge clk);
        req = 1'b1; addr = 16'h0020; rw_n = 1'b0; ebit = 1'b0; write_data = 16'h1234;
        @(posedge clk); #1;
        req = 1'b0;
        chk("abort.busy_pre", {15'h0, busy}, 16'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.busy_rst", {15'h0, busy}, 16'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort.ack1",  {15'h0, ack},  16'h0);
        chk("abort.busy1", {15'h0, busy}, 16'h0);
        @(posedge clk); #1;
        chk("abort.ack2",  {15'h0, ack},  16'h0);
        xfer("r20",   16'h0020, 1'b1, 1'b0, 16'h0000, 16'h0BAD, 1'b0);

        // Reset mid-cycle while in RESP clears outputs at once
        @(negedge clk);
        req = 1'b1; addr = 16'h0010; rw_n = 1'b1; ebit = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rstresp.ack_pre", {15'h0, ack}, 16'h1);
        chk("rstresp.rd_pre",  read_data,    16'hC377);
        #2 rst_n = 1'b0;
        #1;
        chk("rstresp.ack",  {15'h0, ack},  16'h0);
        chk("rstresp.err",  {15'h0, err},  16'h0);
        chk("rstresp.busy", {15'h0, busy}, 16'h0);
        chk("rstresp.rd",   read_data,     16'h0);
        @(negedge clk); rst_n = 1'b1;

        // First request after reset is accepted; memory survived reset
        xfer("post_rst", 16'h0011, 1'b1, 1'b1, 16'h0000, 16'h00C3, 1'b0);
        xfer("post_r20", 16'h0020, 1'b1, 1'b0, 16'h0000, 16'h0BAD, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
